// File: rtl/stream_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : stream_pkg                                                   |
// | Description : Shared constants and types for the stream command path.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package stream_pkg;

  localparam int BEAT_BYTES      = 8;
  localparam int BURST_CNT_WIDTH = 9;
  localparam int AXLEN_WIDTH     = 8;

  // Field widths of the master-side bundle; the splitter defaults match these.
  localparam int CMD_ADDR_WIDTH  = 32;
  localparam int CMD_ID_WIDTH    = 6;

  typedef enum logic {
    SPLIT_IDLE  = 1'b0,
    SPLIT_ISSUE = 1'b1
  } split_state_t;

  typedef struct packed {
    logic [CMD_ADDR_WIDTH-1:0]  addr;
    logic [BURST_CNT_WIDTH-1:0] burst_count;
    logic [CMD_ID_WIDTH-1:0]    id;
    logic                       last;
  } stream_cmd_t;

endpackage : stream_pkg

`default_nettype wire

// File: rtl/stream_page_bound.sv
// +----------------------------------------------------------------------------+
// | Module      : stream_page_bound                                            |
// | Description : Combinational chunk sizing and next-address arithmetic for a |
// |               command clipped at a page boundary.                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module stream_page_bound
  import stream_pkg::*;
#(
  parameter int ADDR_WIDTH          = 32,
  parameter int PAGE_OFFSET_WIDTH   = 12,
  parameter int BURSTS_PER_PAGE     = 512,
  parameter int BURSTS_PER_PAGE_LOG = 9
) (
  input  logic [ADDR_WIDTH-1:0]      addr,
  input  logic [AXLEN_WIDTH-1:0]     len,
  output logic [BURST_CNT_WIDTH-1:0] count,
  output logic                       last,
  output logic [AXLEN_WIDTH-1:0]     len_next,
  output logic [ADDR_WIDTH-1:0]      addr_next
);

  localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);
  localparam int PAGE_WIDTH = ADDR_WIDTH - PAGE_OFFSET_WIDTH;

  localparam logic [BURSTS_PER_PAGE_LOG:0] c_page_beats =
    (BURSTS_PER_PAGE_LOG+1)'(BURSTS_PER_PAGE);

  logic [BURSTS_PER_PAGE_LOG-1:0] w_beat_offset;
  logic [BURSTS_PER_PAGE_LOG:0]   w_remaining;
  logic [BURST_CNT_WIDTH-1:0]     w_len_p1;
  logic [PAGE_WIDTH-1:0]          w_page_next;
  logic                           w_unused_byte_bits;

  // Byte-within-beat bits never influence beat arithmetic.
  assign w_unused_byte_bits = ^addr[BEAT_SHIFT-1:0];

  assign w_beat_offset = addr[PAGE_OFFSET_WIDTH-1:BEAT_SHIFT];
  assign w_remaining   = c_page_beats - {1'b0, w_beat_offset};

  // Nine bits wide so that len=255 yields 256 without wrapping.
  assign w_len_p1 = BURST_CNT_WIDTH'(len) + BURST_CNT_WIDTH'(1);

  // An aligned address gives a full page of room, covering the aligned case.
  assign last  = ({1'b0, w_len_p1} <= w_remaining);
  assign count = last ? w_len_p1 : w_remaining[BURST_CNT_WIDTH-1:0];

  assign len_next = len - count[AXLEN_WIDTH-1:0];

  // Page number wraps naturally at the top of the address space.
  assign w_page_next = addr[ADDR_WIDTH-1:PAGE_OFFSET_WIDTH] + PAGE_WIDTH'(1);
  assign addr_next   = {w_page_next, {PAGE_OFFSET_WIDTH{1'b0}}};

endmodule : stream_page_bound

`default_nettype wire

// File: rtl/stream_cmd_splitter.sv
// +----------------------------------------------------------------------------+
// | Module      : stream_cmd_splitter                                          |
// | Description : Accepts AXI-style commands and issues page-bounded chunks.   |
// |               Define STREAM_CMD_SPLITTER_STATS_EN for handshake counters.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module stream_cmd_splitter
  import stream_pkg::*;
#(
  parameter int SHIELD_ADDR_WIDTH   = CMD_ADDR_WIDTH,
  parameter int PAGE_OFFSET_WIDTH   = 12,
  parameter int BURSTS_PER_PAGE     = 512,
  parameter int BURSTS_PER_PAGE_LOG = 9,
  parameter int ID_WIDTH            = CMD_ID_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [SHIELD_ADDR_WIDTH-1:0] s_axaddr,
  input  logic [AXLEN_WIDTH-1:0]       s_axlen,
  input  logic [ID_WIDTH-1:0]          s_axid,
  input  logic                         s_valid,
  output logic                         s_ready,
  output logic [SHIELD_ADDR_WIDTH-1:0] m_addr,
  output logic [BURST_CNT_WIDTH-1:0]   m_burst_count,
  output logic [ID_WIDTH-1:0]          m_id,
  output logic                         m_last,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic                         busy
`ifdef STREAM_CMD_SPLITTER_STATS_EN
  ,
  output logic [31:0]                  stat_cmd_cnt,
  output logic [31:0]                  stat_chunk_cnt
`endif
);

  split_state_t                 r_state;
  logic [SHIELD_ADDR_WIDTH-1:0] r_cur_addr;
  logic [AXLEN_WIDTH-1:0]       r_cur_len;
  logic [ID_WIDTH-1:0]          r_cur_id;

  logic [BURST_CNT_WIDTH-1:0]   w_count;
  logic                         w_last;
  logic [AXLEN_WIDTH-1:0]       w_len_next;
  logic [SHIELD_ADDR_WIDTH-1:0] w_addr_next;
  logic                         w_issue;
  logic                         w_m_fire;
  logic                         w_s_fire;
  stream_cmd_t                  w_m_cmd;

  stream_page_bound #(
    .ADDR_WIDTH          (SHIELD_ADDR_WIDTH),
    .PAGE_OFFSET_WIDTH   (PAGE_OFFSET_WIDTH),
    .BURSTS_PER_PAGE     (BURSTS_PER_PAGE),
    .BURSTS_PER_PAGE_LOG (BURSTS_PER_PAGE_LOG)
  ) u_page_bound (
    .addr      (r_cur_addr),
    .len       (r_cur_len),
    .count     (w_count),
    .last      (w_last),
    .len_next  (w_len_next),
    .addr_next (w_addr_next)
  );

  assign w_issue  = (r_state == SPLIT_ISSUE);
  assign w_m_fire = w_issue && m_ready;

  // Ready also opens on the final chunk's handshake so commands stream without a bubble.
  assign s_ready  = (r_state == SPLIT_IDLE) || (w_m_fire && w_last);
  assign w_s_fire = s_valid && s_ready;

  assign w_m_cmd = '{
    addr:        r_cur_addr,
    burst_count: w_count,
    id:          r_cur_id,
    last:        w_last
  };

  assign m_addr        = w_m_cmd.addr;
  assign m_burst_count = w_m_cmd.burst_count;
  assign m_id          = w_m_cmd.id;
  assign m_last        = w_m_cmd.last;
  assign m_valid       = w_issue;
  assign busy          = w_issue;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= SPLIT_IDLE;
      r_cur_addr <= '0;
      r_cur_len  <= '0;
      r_cur_id   <= '0;
    end else if (w_s_fire) begin
      r_state    <= SPLIT_ISSUE;
      r_cur_addr <= s_axaddr;
      r_cur_len  <= s_axlen;
      r_cur_id   <= s_axid;
    end else if (w_m_fire) begin
      if (w_last) begin
        r_state <= SPLIT_IDLE;
      end else begin
        r_cur_addr <= w_addr_next;
        r_cur_len  <= w_len_next;
      end
    end
  end

`ifdef STREAM_CMD_SPLITTER_STATS_EN
  logic [31:0] r_stat_cmd_cnt;
  logic [31:0] r_stat_chunk_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_cmd_cnt   <= '0;
      r_stat_chunk_cnt <= '0;
    end else begin
      if (w_s_fire) r_stat_cmd_cnt   <= r_stat_cmd_cnt + 32'd1;
      if (w_m_fire) r_stat_chunk_cnt <= r_stat_chunk_cnt + 32'd1;
    end
  end

  assign stat_cmd_cnt   = r_stat_cmd_cnt;
  assign stat_chunk_cnt = r_stat_chunk_cnt;
`endif

endmodule : stream_cmd_splitter

`default_nettype wire

// File: tb/tb_stream_cmd_splitter.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_stream_cmd_splitter                                       |
// | Description : Self-checking bench with a command-level chunk model.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_stream_cmd_splitter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] s_axaddr = '0;
  logic [7:0]  s_axlen = '0;
  logic [5:0]  s_axid = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] m_addr;
  logic [8:0]  m_burst_count;
  logic [5:0]  m_id;
  logic        m_last;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic        busy;
`ifdef STREAM_CMD_SPLITTER_STATS_EN
  logic [31:0] stat_cmd_cnt;
  logic [31:0] stat_chunk_cnt;
`endif

  stream_cmd_splitter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axaddr      (s_axaddr),
    .s_axlen       (s_axlen),
    .s_axid        (s_axid),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .m_addr        (m_addr),
    .m_burst_count (m_burst_count),
    .m_id          (m_id),
    .m_last        (m_last),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .busy          (busy)
`ifdef STREAM_CMD_SPLITTER_STATS_EN
    ,
    .stat_cmd_cnt  (stat_cmd_cnt),
    .stat_chunk_cnt(stat_chunk_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          cnt;
    int          id;
    bit          last;
    int          cyc;
  } chunk_t;

  chunk_t exp_q[$];
  chunk_t log_q[$];
  int     n_checks = 0;
  int     n_errors = 0;
  int     cyc = 0;
  int     cmds_seen = 0;
  int     chunks_seen = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out", name);
  endtask

  // Whole-command model: beats up to the page end go first, the rest go page-aligned.
  function automatic void model_cmd(input logic [31:0] a, input int len, input int id);
    int total, room, first;
    chunk_t c;
    total = len + 1;
    room  = 512 - int'(a[11:3]);
    first = (total < room) ? total : room;
    c.addr = a; c.cnt = first; c.id = id; c.last = (first == total); c.cyc = 0;
    exp_q.push_back(c);
    if (first != total) begin
      c.addr = {a[31:12] + 20'd1, 12'h000};
      c.cnt  = total - first;
      c.last = 1'b1;
      exp_q.push_back(c);
    end
  endfunction

  always @(negedge clk) begin
    bit     exp_v, exp_sr;
    chunk_t c;
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      cmds_seen = 0;
      chunks_seen = 0;
      chk("rst_m_valid", {63'd0, m_valid}, 64'd0);
      chk("rst_s_ready", {63'd0, s_ready}, 64'd1);
    end else begin
      exp_v  = (exp_q.size() != 0);
      exp_sr = (exp_q.size() == 0) || (m_ready && exp_q.size() == 1);
      chk("m_valid", {63'd0, m_valid}, {63'd0, exp_v});
      chk("s_ready", {63'd0, s_ready}, {63'd0, exp_sr});
      chk("busy",    {63'd0, busy},    {63'd0, exp_v});
      if (exp_v && m_valid) begin
        chk("m_addr",        {32'd0, m_addr},         {32'd0, exp_q[0].addr});
        chk("m_burst_count", {55'd0, m_burst_count},  64'(exp_q[0].cnt));
        chk("m_id",          {58'd0, m_id},           64'(exp_q[0].id));
        chk("m_last",        {63'd0, m_last},         {63'd0, exp_q[0].last});
        if (m_ready) begin
          c.addr = m_addr; c.cnt = int'(m_burst_count); c.id = int'(m_id);
          c.last = m_last; c.cyc = cyc;
          log_q.push_back(c);
          void'(exp_q.pop_front());
          chunks_seen++;
        end
      end
      if (s_valid && exp_sr) begin
        model_cmd(s_axaddr, int'(s_axlen), int'(s_axid));
        cmds_seen++;
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [7:0] l, input logic [5:0] id);
    bit ok = 1'b0;
    @(posedge clk); #1;
    s_axaddr = a; s_axlen = l; s_axid = id; s_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (s_ready) ok = 1'b1;
    end
    if (!ok) fail_now("send");
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk); #1;
      if (!m_valid) ok = 1'b1;
    end
    if (!ok) fail_now("wait_idle");
  endtask

  task automatic check_log(input string name, input int idx, input logic [31:0] a,
                           input int cnt, input bit last, input int id);
    if (idx >= log_q.size()) begin
      fail_now(name);
    end else begin
      chk({name, "_addr"}, {32'd0, log_q[idx].addr}, {32'd0, a});
      chk({name, "_cnt"},  64'(log_q[idx].cnt),      64'(cnt));
      chk({name, "_last"}, {63'd0, log_q[idx].last}, {63'd0, last});
      chk({name, "_id"},   64'(log_q[idx].id),       64'(id));
    end
  endtask

  initial begin
    int          b;
    logic [31:0] h_addr;
    logic [8:0]  h_cnt;
    logic [5:0]  h_id;
    logic        h_last;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk); #1;
    chk("reset_m_valid", {63'd0, m_valid}, 64'd0);
    chk("reset_s_ready", {63'd0, s_ready}, 64'd1);
    chk("reset_busy",    {63'd0, busy},    64'd0);
    chk("reset_m_addr",  {32'd0, m_addr},  64'd0);
    chk("reset_m_id",    {58'd0, m_id},    64'd0);
`ifdef STREAM_CMD_SPLITTER_STATS_EN
    chk("reset_stat_cmd",   {32'd0, stat_cmd_cnt},   64'd0);
    chk("reset_stat_chunk", {32'd0, stat_chunk_cnt}, 64'd0);
`endif

    // Aligned full 256-beat command
    b = log_q.size();
    send(32'h0000_1000, 8'd255, 6'd1);
    @(negedge clk); #1;
    chk("aligned_valid",  {63'd0, m_valid}, 64'd1);
    chk("aligned_last",   {63'd0, m_last},  64'd1);
    chk("aligned_sready", {63'd0, s_ready}, 64'd1);
    wait_idle();
    check_log("aligned", b, 32'h0000_1000, 256, 1'b1, 1);

    // Page crossing
    b = log_q.size();
    send(32'h0000_1F00, 8'd63, 6'd5);
    wait_idle();
    check_log("cross0", b,     32'h0000_1F00, 32, 1'b0, 5);
    check_log("cross1", b + 1, 32'h0000_2000, 32, 1'b1, 5);

    // Last beat of a page
    b = log_q.size();
    send(32'h0000_1FF8, 8'd0, 6'd2);
    wait_idle();
    send(32'h0000_1FF8, 8'd1, 6'd3);
    wait_idle();
    check_log("edge1",  b,     32'h0000_1FF8, 1, 1'b1, 2);
    check_log("edge2a", b + 1, 32'h0000_1FF8, 1, 1'b0, 3);
    check_log("edge2b", b + 2, 32'h0000_2000, 1, 1'b1, 3);

    // Backpressure: outputs hold and no new command is taken
    m_ready = 1'b0;
    b = log_q.size();
    send(32'h0000_3004, 8'd10, 6'd7);
    @(negedge clk); #1;
    h_addr = m_addr; h_cnt = m_burst_count; h_id = m_id; h_last = m_last;
    chk("bp_addr0", {32'd0, h_addr}, 64'h3004);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("bp_addr",   {32'd0, m_addr},        {32'd0, h_addr});
      chk("bp_cnt",    {55'd0, m_burst_count}, {55'd0, h_cnt});
      chk("bp_id",     {58'd0, m_id},          {58'd0, h_id});
      chk("bp_last",   {63'd0, m_last},        {63'd0, h_last});
      chk("bp_sready", {63'd0, s_ready},       64'd0);
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    wait_idle();
    check_log("bp", b, 32'h0000_3004, 11, 1'b1, 7);

    // Back-to-back: second command taken on the last chunk's handshake
    b = log_q.size();
    send(32'h0000_1F00, 8'd63, 6'd8);
    send(32'h0000_5000, 8'd3, 6'd9);
    wait_idle();
    check_log("b2b0", b,     32'h0000_1F00, 32, 1'b0, 8);
    check_log("b2b1", b + 1, 32'h0000_2000, 32, 1'b1, 8);
    check_log("b2b2", b + 2, 32'h0000_5000, 4,  1'b1, 9);
    if (log_q.size() >= b + 3)
      chk("b2b_gap", 64'(log_q[b+2].cyc - log_q[b+1].cyc), 64'd1);
    else
      fail_now("b2b_gap");

    // Top-of-memory wrap
    b = log_q.size();
    send(32'hFFFF_FF00, 8'd63, 6'd10);
    wait_idle();
    check_log("wrap0", b,     32'hFFFF_FF00, 32, 1'b0, 10);
    check_log("wrap1", b + 1, 32'h0000_0000, 32, 1'b1, 10);

`ifdef STREAM_CMD_SPLITTER_STATS_EN
    chk("stat_cmd",   {32'd0, stat_cmd_cnt},   64'(cmds_seen));
    chk("stat_chunk", {32'd0, stat_chunk_cnt}, 64'(chunks_seen));
`endif

    // Asynchronous reset with a chunk in flight
    m_ready = 1'b0;
    send(32'h0000_7000, 8'd5, 6'd3);
    #2;
    chk("pre_rst_valid", {63'd0, m_valid}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid",  {63'd0, m_valid}, 64'd0);
    chk("async_rst_sready", {63'd0, s_ready}, 64'd1);
    chk("async_rst_busy",   {63'd0, busy},    64'd0);
`ifdef STREAM_CMD_SPLITTER_STATS_EN
    chk("async_rst_stat_cmd",   {32'd0, stat_cmd_cnt},   64'd0);
    chk("async_rst_stat_chunk", {32'd0, stat_chunk_cnt}, 64'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_ready = 1'b1;
    b = log_q.size();
    send(32'h0000_8008, 8'd2, 6'd4);
    wait_idle();
    check_log("post_rst", b, 32'h0000_8008, 3, 1'b1, 4);

    chk("model_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule : tb_stream_cmd_splitter

`default_nettype wire
